// File: rtl/workbench.sv
// Phase normaliser into [0, PERIOD) with an optional wrapped first-order tracking filter (macro WORKBENCH_FILTER_EN).
// Latency: 2 clock edges from i_value to the o_value update that uses it.
// Backpressure: none; a new sample is accepted every cycle with no handshake.
module workbench #(
  parameter int PERIOD = 1496,
  parameter int SHIFT  = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_value,
  output logic [15:0] o_value
);

  // All arithmetic is done 18 bits wide so no intermediate can overflow.
  localparam logic signed [17:0] P_S   = 18'(PERIOD);
  localparam logic signed [17:0] NEG_P = -18'(PERIOD);
  localparam logic signed [17:0] TWO_P = 18'(2 * PERIOD);

  logic signed [15:0] x_r;
  logic signed [17:0] x_ext;
  logic        [15:0] xn;
  logic        [15:0] y_r;

  assign x_ext   = {{2{x_r[15]}}, x_r};
  assign o_value = y_r;

  // Capture the raw signed sample every cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) x_r <= '0;
    else         x_r <= $signed(i_value);
  end

  // Fold one period either side into range; anything further out is clamped.
  always_comb begin
    xn = '0;
    if (x_ext < NEG_P)      xn = '0;
    else if (x_ext[17])     xn = 16'(x_ext + P_S);
    else if (x_ext < P_S)   xn = 16'(x_ext);
    else if (x_ext < TWO_P) xn = 16'(x_ext - P_S);
    else                    xn = 16'(P_S - 18'sd1);
  end

`ifdef WORKBENCH_FILTER_EN
  localparam logic signed [17:0] HALF     = 18'(PERIOD / 2);
  localparam logic signed [17:0] NEG_HALF = -18'(PERIOD / 2);
  localparam logic signed [17:0] RND      = 18'(2 ** (SHIFT - 1));

  logic signed [17:0] e_raw;
  logic signed [17:0] e;
  logic signed [17:0] step;
  logic signed [17:0] sum;
  logic signed [17:0] sum_w;

  // Shortest-path error on the circle, rounded gain step, and wrapped accumulate.
  always_comb begin
    e_raw = $signed({2'b00, xn}) - $signed({2'b00, y_r});
    if (e_raw >= HALF)         e = e_raw - P_S;
    else if (e_raw < NEG_HALF) e = e_raw + P_S;
    else                       e = e_raw;
    // Arithmetic shift after adding half an LSB: exact halves round toward +inf.
    step = (e + RND) >>> SHIFT;
    sum  = $signed({2'b00, y_r}) + step;
    if (sum[17])          sum_w = sum + P_S;
    else if (sum >= P_S)  sum_w = sum - P_S;
    else                  sum_w = sum;
  end

  // Filter state doubles as the output register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) y_r <= '0;
    else         y_r <= 16'(sum_w);
  end
`else
  // Pure normaliser: register the folded sample straight out.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) y_r <= '0;
    else         y_r <= xn;
  end
`endif

endmodule

// File: tb/tb_workbench.sv
`timescale 1ns/1ps
module tb_workbench;
  localparam int P = 1496;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_value = '0;
  logic [15:0] o_value;

  int n_vec = 0;
  int n_err = 0;
  // Reference model state: sample captured at the last edge, and the expected output.
  int m_x = 0;
  int m_y = 0;

  workbench #(.PERIOD(P), .SHIFT(S)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_value (i_value),
    .o_value (o_value)
  );

  always #2.5 clk = ~clk;

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int norm(input int x);
    if (x < -P)    return 0;
    if (x < 0)     return x + P;
    if (x < P)     return x;
    if (x < 2 * P) return x - P;
    return P - 1;
  endfunction

  function automatic int model_next(input int y, input int xn);
`ifdef WORKBENCH_FILTER_EN
    int e;
    int st;
    e  = ((((xn - y) + P / 2) % P) + P) % P - P / 2;
    st = fdiv(e + (1 << (S - 1)), 1 << S);
    return (((y + st) % P) + P) % P;
`else
    return xn + 0 * y;
`endif
  endfunction

  // Drive one sample, take one edge, advance the model, settle past the edge.
  task automatic apply(input int v);
    logic signed [15:0] sv;
    sv = 16'(v);
    i_value = sv;
    @(posedge clk);
    m_y = model_next(m_y, norm(m_x));
    m_x = int'(sv);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #5;
    rst = 1'b0;
    m_x = 0;
    m_y = 0;
  endtask

  task automatic test_reset();
    int v;
    i_value = 16'($urandom_range(0, 65535));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (o_value !== 16'd0) begin
      n_err++; $display("FAIL reset_immediate: o_value=%0d expected 0", o_value);
    end
    #5;
    n_vec++;
    if (o_value !== 16'd0) begin
      n_err++; $display("FAIL reset_held: o_value=%0d expected 0", o_value);
    end
    rst = 1'b0;
    m_x = 0;
    m_y = 0;
    v = int'($urandom_range(0, 65535));
    apply(v);
    n_vec++;
    if (o_value !== 16'd0) begin
      n_err++; $display("FAIL reset_edge1: o_value=%0d expected 0", o_value);
    end
    apply(v);
    n_vec++;
    if (o_value !== 16'(m_y)) begin
      n_err++; $display("FAIL reset_edge2: o_value=%0d expected %0d", o_value, m_y);
    end
  endtask

`ifndef WORKBENCH_FILTER_EN
  task automatic test_normalise();
    int vals [3] = '{8, 1500, -10};
    int exps [3] = '{8, 4, 1486};
    int bnd  [12] = '{-32768, -1497, -1496, -1495, -1, 0, 1495, 1496, 2991, 2992, 4000, 32767};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(vals[i]);
      apply(vals[i]);
      n_vec++;
      if (o_value !== 16'(exps[i])) begin
        n_err++; $display("FAIL normalise_directed[%0d]: o_value=%0d expected %0d", i, o_value, exps[i]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      apply(bnd[i]);
      apply(bnd[i]);
      n_vec++;
      if (o_value !== 16'(m_y)) begin
        n_err++; $display("FAIL normalise_boundary x=%0d: o_value=%0d expected %0d", bnd[i], o_value, m_y);
      end
    end
  endtask
`else
  task automatic test_convergence();
    int exps [3] = '{10, 19, 27};
    do_reset();
    apply(80);
    for (int i = 0; i < 3; i++) begin
      apply(80);
      n_vec++;
      if (o_value !== 16'(exps[i])) begin
        n_err++; $display("FAIL converge_step[%0d]: o_value=%0d expected %0d", i, o_value, exps[i]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      apply(80);
      n_vec++;
      if (o_value !== 16'(m_y)) begin
        n_err++; $display("FAIL converge_track[%0d]: o_value=%0d expected %0d", i, o_value, m_y);
      end
    end
    n_vec++;
    if (int'(o_value) < 76 || int'(o_value) > 84) begin
      n_err++; $display("FAIL converge_settle: o_value=%0d expected within 4 of 80", o_value);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    apply(1400);
    apply(1400);
    n_vec++;
    if (o_value !== 16'd1484) begin
      n_err++; $display("FAIL shortest_wrap: o_value=%0d expected 1484", o_value);
    end
  endtask
`endif

  task automatic test_clamp();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply((i % 2 == 0) ? -32768 : 4000);
      n_vec++;
      if (o_value !== 16'(m_y) || int'(o_value) >= P) begin
        n_err++; $display("FAIL clamp[%0d]: o_value=%0d expected %0d", i, o_value, m_y);
      end
    end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 300; i++) begin
      if (i % 3 == 0) v = int'($urandom_range(0, 65535)) - 32768;
      else            v = int'($urandom_range(0, 3 * P + 40)) - P - 20;
      apply(v);
      n_vec++;
      if (o_value !== 16'(m_y)) begin
        n_err++; $display("FAIL random[%0d] x=%0d: o_value=%0d expected %0d", i, v, o_value, m_y);
      end
    end
  endtask

  task automatic test_sweep();
    int v;
    do_reset();
    v = int'($urandom_range(0, 2 * P - 1)) - P;
    for (int i = 0; i < 20; i++) begin
      apply(v);
      n_vec++;
      if ($isunknown(o_value) || int'(o_value) >= P || o_value !== 16'(m_y)) begin
        n_err++; $display("FAIL sweep[%0d] x=%0d: o_value=%0h expected %0d", i, v, o_value, m_y);
      end
      v = (v * 9) / 10 - 10;
      if (v < -P) v = v + P;
      if (v >= P) v = v - P;
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 6; i++) apply(int'($urandom_range(0, 2 * P)));
    do_reset();
    n_vec++;
    if (o_value !== 16'd0) begin
      n_err++; $display("FAIL midstream_reset: o_value=%0d expected 0", o_value);
    end
    for (int i = 0; i < 4; i++) begin
      apply(int'($urandom_range(0, 2 * P)));
      n_vec++;
      if (o_value !== 16'(m_y)) begin
        n_err++; $display("FAIL midstream_after[%0d]: o_value=%0d expected %0d", i, o_value, m_y);
      end
    end
  endtask

  initial begin
    test_reset();
`ifndef WORKBENCH_FILTER_EN
    test_normalise();
`else
    test_convergence();
    test_wrap();
`endif
    test_clamp();
    test_random();
    test_sweep();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
